// File: rtl/eot_stream_fifo_pkg.sv
// Shared stream definitions: a token is {eot, payload}, with the close flag in the top bit.
package eot_stream_fifo_pkg;

  localparam int EOT_BIT       = 32;
  localparam int PAYLOAD_WIDTH = 32;

  typedef struct packed {
    logic                     eot;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } token_t;

  localparam int TOKEN_WIDTH = $bits(token_t);

endpackage

// File: rtl/eot_stream_fifo_if.sv
// FIFO-style stream handshake: producer writes din/write gated by full_n,
// consumer sees fall-through dout/empty_n and pops with read.
interface eot_stream_fifo_if
  import eot_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH
);

  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  if_read;

  modport master (
    output if_din, if_write, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_din, if_write, if_read,
    output if_full_n, if_dout, if_empty_n
  );

endinterface

// File: rtl/stream_fifo_mem.sv
// Simple dual-port token storage: synchronous write, asynchronous read (0-cycle read latency).
// No flow control here; the caller only writes free entries.
module stream_fifo_mem
  import eot_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  ap_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/eot_stream_fifo.sv
// First-word fall-through token FIFO with per-stream element counting; 1-cycle write-to-read latency.
// Writes stall via if_full_n, reads via if_empty_n; all status outputs are registered.
module eot_stream_fifo
  import eot_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  eot_stream_fifo_if.slave      fifo_if,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [63:0]           elem_count,
  output logic [63:0]           last_len,
  output logic                  eot_pulse
);

  localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   occ_q;
  logic [ADDR_WIDTH:0]   occ_next;
  logic                  full_n_q;
  logic                  empty_n_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  head_eot;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [63:0]           elem_cnt_q;
  logic [63:0]           last_len_q;
  logic                  eot_pulse_q;

  // Acceptance uses only registered status, so a full FIFO never takes a write
  // even when a read frees an entry in the same cycle.
  assign wr_acc   = fifo_if.if_write & full_n_q;
  assign rd_acc   = fifo_if.if_read & empty_n_q;
  assign head_eot = head_dat[EOT_BIT];

  always_comb begin
    occ_next = occ_q;
    case ({wr_acc, rd_acc})
      2'b10:   occ_next = occ_q + 1'b1;
      2'b01:   occ_next = occ_q - 1'b1;
      default: occ_next = occ_q;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ_q     <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      occ_q     <= occ_next;
      full_n_q  <= (occ_next != OCC_FULL);
      empty_n_q <= (occ_next != '0);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      elem_cnt_q  <= '0;
      last_len_q  <= '0;
      eot_pulse_q <= 1'b0;
    end else begin
      eot_pulse_q <= rd_acc & head_eot;
      if (rd_acc) begin
        if (head_eot) begin
          last_len_q <= elem_cnt_q;
          elem_cnt_q <= '0;
        end else begin
          elem_cnt_q <= elem_cnt_q + 64'd1;
        end
      end
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .ap_clk  (ap_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_dat  (fifo_if.if_din),
    .rd_addr (rd_ptr),
    .rd_dat  (head_dat)
  );

  assign fifo_if.if_dout    = head_dat;
  assign fifo_if.if_full_n  = full_n_q;
  assign fifo_if.if_empty_n = empty_n_q;
  assign occupancy          = occ_q;
  assign elem_count         = elem_cnt_q;
  assign last_len           = last_len_q;
  assign eot_pulse          = eot_pulse_q;

endmodule

// File: tb/tb_eot_stream_fifo.sv
// Directed bench for eot_stream_fifo: streaming, full/empty corners, EoT counting, async reset.
module tb_eot_stream_fifo;
  import eot_stream_fifo_pkg::*;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [2:0]  occupancy;
  logic [63:0] elem_count;
  logic [63:0] last_len;
  logic        eot_pulse;

  int checks;
  int errors;

  eot_stream_fifo_if #(.DATA_WIDTH(33)) fifo_if ();

  eot_stream_fifo #(
    .DATA_WIDTH (33),
    .DEPTH      (4),
    .ADDR_WIDTH (2)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .fifo_if    (fifo_if),
    .occupancy  (occupancy),
    .elem_count (elem_count),
    .last_len   (last_len),
    .eot_pulse  (eot_pulse)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n        = 1'b0;
    fifo_if.if_din   = '0;
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    #3;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    checks++; if (fifo_if.if_empty_n !== 1'b0) begin errors++; $display("FAIL rst_empty_n got %b exp 0", fifo_if.if_empty_n); end
    checks++; if (fifo_if.if_full_n !== 1'b0) begin errors++; $display("FAIL rst_full_n got %b exp 0", fifo_if.if_full_n); end
    checks++; if (elem_count !== 64'd0) begin errors++; $display("FAIL rst_elem got %0d exp 0", elem_count); end
    checks++; if (last_len !== 64'd0) begin errors++; $display("FAIL rst_last got %0d exp 0", last_len); end
    checks++; if (eot_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %b exp 0", eot_pulse); end
    cyc();
    ap_rst_n = 1'b1;
    cyc();
    checks++; if (fifo_if.if_full_n !== 1'b1) begin errors++; $display("FAIL rel_full_n got %b exp 1", fifo_if.if_full_n); end
    checks++; if (fifo_if.if_empty_n !== 1'b0) begin errors++; $display("FAIL rel_empty_n got %b exp 0", fifo_if.if_empty_n); end
  endtask

  task automatic test_stream();
    token_t toks [6];
    int     n_rd;
    int     pulses;
    toks[0] = 33'h0_3F80_0000;
    toks[1] = 33'h0_4040_0000;
    toks[2] = 33'h0_40A0_0000;
    toks[3] = 33'h0_40E0_0000;
    toks[4] = 33'h0_4110_0000;
    toks[5] = 33'h1_0000_0000;
    n_rd   = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      fifo_if.if_read  = 1'b1;
      fifo_if.if_write = (c < 6);
      fifo_if.if_din   = (c < 6) ? toks[c] : '0;
      if (fifo_if.if_empty_n === 1'b1) begin
        checks++;
        if (n_rd > 5 || fifo_if.if_dout !== toks[n_rd]) begin
          errors++;
          $display("FAIL stream_rd%0d got %h exp %h", n_rd, fifo_if.if_dout, toks[n_rd % 6]);
        end
        n_rd++;
      end
      cyc();
      if (eot_pulse === 1'b1) pulses++;
    end
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    checks++; if (n_rd !== 6) begin errors++; $display("FAIL stream_nreads got %0d exp 6", n_rd); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL stream_pulses got %0d exp 1", pulses); end
    checks++; if (last_len !== 64'd5) begin errors++; $display("FAIL stream_last got %0d exp 5", last_len); end
    checks++; if (elem_count !== 64'd0) begin errors++; $display("FAIL stream_elem got %0d exp 0", elem_count); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_full();
    fifo_if.if_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fifo_if.if_write = 1'b1;
      fifo_if.if_din   = 33'h0_0000_00A0 + 33'(i);
      cyc();
      if (i == 3) begin
        checks++; if (fifo_if.if_full_n !== 1'b0) begin errors++; $display("FAIL full_after4 got %b exp 0", fifo_if.if_full_n); end
      end
    end
    fifo_if.if_write = 1'b0;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    checks++; if (fifo_if.if_full_n !== 1'b0) begin errors++; $display("FAIL full_after5 got %b exp 0", fifo_if.if_full_n); end
    checks++; if (fifo_if.if_dout !== 33'h0_0000_00A0) begin errors++; $display("FAIL full_head got %h exp a0", fifo_if.if_dout); end
  endtask

  task automatic test_full_rw();
    fifo_if.if_write = 1'b1;
    fifo_if.if_read  = 1'b1;
    fifo_if.if_din   = 33'h0_0000_00BB;
    cyc();
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fullrw_occ got %0d exp 3", occupancy); end
    checks++; if (fifo_if.if_full_n !== 1'b1) begin errors++; $display("FAIL fullrw_full_n got %b exp 1", fifo_if.if_full_n); end
    checks++; if (elem_count !== 64'd1) begin errors++; $display("FAIL fullrw_elem got %0d exp 1", elem_count); end
    // Remaining contents must be A1..A3: neither the 5th write nor 0xBB got in.
    fifo_if.if_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fifo_if.if_dout !== 33'h0_0000_00A1 + 33'(i)) begin
        errors++;
        $display("FAIL drain_rd%0d got %h exp %h", i, fifo_if.if_dout, 33'h0_0000_00A1 + 33'(i));
      end
      cyc();
    end
    fifo_if.if_read = 1'b0;
    checks++; if (fifo_if.if_empty_n !== 1'b0) begin errors++; $display("FAIL drain_empty_n got %b exp 0", fifo_if.if_empty_n); end
    checks++; if (elem_count !== 64'd4) begin errors++; $display("FAIL drain_elem got %0d exp 4", elem_count); end
  endtask

  task automatic test_empty_rw();
    fifo_if.if_write = 1'b1;
    fifo_if.if_read  = 1'b1;
    fifo_if.if_din   = 33'h0_0000_00CC;
    cyc();
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b0;
    checks++; if (fifo_if.if_empty_n !== 1'b1) begin errors++; $display("FAIL emptyrw_empty_n got %b exp 1", fifo_if.if_empty_n); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL emptyrw_occ got %0d exp 1", occupancy); end
    checks++; if (elem_count !== 64'd4) begin errors++; $display("FAIL emptyrw_elem got %0d exp 4", elem_count); end
    checks++; if (fifo_if.if_dout !== 33'h0_0000_00CC) begin errors++; $display("FAIL emptyrw_dout got %h exp cc", fifo_if.if_dout); end
    fifo_if.if_read = 1'b1;
    cyc();
    fifo_if.if_read = 1'b0;
    checks++; if (elem_count !== 64'd5) begin errors++; $display("FAIL emptyrw_elem2 got %0d exp 5", elem_count); end
  endtask

  task automatic test_back_to_back_eot();
    fifo_if.if_read  = 1'b0;
    fifo_if.if_write = 1'b1;
    fifo_if.if_din   = 33'h1_0000_0001;
    cyc();
    fifo_if.if_din   = 33'h1_0000_0002;
    cyc();
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b1;
    cyc();
    checks++; if (eot_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse1 got %b exp 1", eot_pulse); end
    checks++; if (last_len !== 64'd5) begin errors++; $display("FAIL b2b_last1 got %0d exp 5", last_len); end
    checks++; if (elem_count !== 64'd0) begin errors++; $display("FAIL b2b_elem1 got %0d exp 0", elem_count); end
    checks++; if (fifo_if.if_dout !== 33'h1_0000_0002) begin errors++; $display("FAIL b2b_head got %h exp 100000002", fifo_if.if_dout); end
    cyc();
    checks++; if (eot_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse2 got %b exp 1", eot_pulse); end
    checks++; if (last_len !== 64'd0) begin errors++; $display("FAIL b2b_last2 got %0d exp 0", last_len); end
    cyc();
    fifo_if.if_read = 1'b0;
    checks++; if (eot_pulse !== 1'b0) begin errors++; $display("FAIL b2b_pulse3 got %b exp 0", eot_pulse); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    fifo_if.if_read  = 1'b0;
    fifo_if.if_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fifo_if.if_din = 33'h0_0000_0010 + 33'(i);
      cyc();
    end
    fifo_if.if_write = 1'b0;
    fifo_if.if_read  = 1'b1;
    cyc();
    cyc();
    fifo_if.if_read  = 1'b0;
    fifo_if.if_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fifo_if.if_din = 33'h0_0000_0020 + 33'(i);
      cyc();
    end
    fifo_if.if_write = 1'b0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_pre_occ got %0d exp 3", occupancy); end
    checks++; if (elem_count !== 64'd2) begin errors++; $display("FAIL mid_pre_elem got %0d exp 2", elem_count); end
    ap_rst_n = 1'b0;
    #2;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
    checks++; if (fifo_if.if_empty_n !== 1'b0) begin errors++; $display("FAIL mid_empty_n got %b exp 0", fifo_if.if_empty_n); end
    checks++; if (fifo_if.if_full_n !== 1'b0) begin errors++; $display("FAIL mid_full_n got %b exp 0", fifo_if.if_full_n); end
    checks++; if (elem_count !== 64'd0) begin errors++; $display("FAIL mid_elem got %0d exp 0", elem_count); end
    checks++; if (last_len !== 64'd0) begin errors++; $display("FAIL mid_last got %0d exp 0", last_len); end
    checks++; if (eot_pulse !== 1'b0) begin errors++; $display("FAIL mid_pulse got %b exp 0", eot_pulse); end
    cyc();
    ap_rst_n = 1'b1;
    cyc();
    checks++; if (fifo_if.if_full_n !== 1'b1) begin errors++; $display("FAIL mid_rel_full_n got %b exp 1", fifo_if.if_full_n); end
    checks++; if (fifo_if.if_empty_n !== 1'b0) begin errors++; $display("FAIL mid_rel_empty_n got %b exp 0", fifo_if.if_empty_n); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_rel_occ got %0d exp 0", occupancy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_full();
    test_full_rw();
    test_empty_rw();
    test_back_to_back_eot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eot_stream_fifo.md
EOT_STREAM_FIFO -- requirements
Module: eot_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 33, full token width: bit 32 is the EoT (close) flag and bits 31:0 are the payload.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (power of two, >= 2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, equal to log2(DEPTH).
REQ-004 SHALL have port ap_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port ap_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port if_din  input  DATA_WIDTH  write data from the upstream producer's c_din.
REQ-007 SHALL have port if_full_n  output  1  high when an entry is free.
REQ-008 SHALL have port if_write  input  1  write request from the producer's c_write.
REQ-009 SHALL have port if_dout  output  DATA_WIDTH  head token, first-word fall-through.
REQ-010 SHALL have port if_empty_n  output  1  high when if_dout holds a valid token.
REQ-011 SHALL have port if_read  input  1  consumer read request.
REQ-012 SHALL have port occupancy  output  ADDR_WIDTH+1  number of stored tokens.
REQ-013 SHALL have port elem_count  output  64  data (non-EoT) tokens read since the last EoT was read.
REQ-014 SHALL have port last_len  output  64  elem_count value captured when the most recent EoT was read.
REQ-015 SHALL have port eot_pulse  output  1  one-cycle pulse in the cycle after an EoT token is read.

Function
REQ-016 SHALL accept a write iff if_write && if_full_n; if_write while full SHALL be ignored, with no state change.
REQ-017 SHALL accept a read iff if_read && if_empty_n; if_read while empty SHALL be ignored.
REQ-018 SHALL make a token written at edge k visible on if_dout/if_empty_n after edge k: one-cycle write-to-read latency, with no empty bypass.
REQ-019 SHALL drive if_dout from the entry at the read pointer; if_dout SHALL be don't-care when if_empty_n=0.
REQ-020 SHALL, on simultaneous accepted read and write, leave occupancy unchanged and advance both pointers.
REQ-021 SHALL, when full with if_read and if_write both asserted, accept only the read; if_full_n SHALL rise the following cycle.
REQ-022 SHALL wrap both pointers from DEPTH-1 to 0; full/empty SHALL be derived from occupancy (0 = empty, DEPTH = full).
REQ-023 SHALL store the EoT bit unmodified and never generate or drop tokens.
REQ-024 SHALL, on an accepted read with bit 32 = 0, increment elem_count by 1, with 64-bit wrap.
REQ-025 SHALL, on an accepted read with bit 32 = 1, load last_len with the current elem_count, clear elem_count to 0, and assert eot_pulse for exactly the next cycle.
REQ-026 SHALL assert eot_pulse on consecutive cycles for back-to-back EoT reads; the second EoT SHALL give last_len = 0.
REQ-027 SHALL register outputs if_full_n, if_empty_n, occupancy, elem_count, last_len and eot_pulse, with no combinational path from if_write or if_read to any of them.

Reset
REQ-028 SHALL, while ap_rst_n=0, force occupancy=0, pointers=0, if_empty_n=0, if_full_n=0, elem_count=0, last_len=0, eot_pulse=0.
REQ-029 SHALL raise if_full_n on the first rising edge after ap_rst_n deasserts.
REQ-030 SHALL, on reset asserted mid-stream, discard all stored tokens immediately; storage contents need not be cleared.

Structure
REQ-031 SHALL take EOT_BIT (32), PAYLOAD_WIDTH (32) and a token typedef {eot, payload} from a shared stream package.
REQ-032 SHALL place storage in one sub-module, stream_fifo_mem (simple dual-port, synchronous write, asynchronous read); pointer, occupancy and counter logic stays in eot_stream_fifo.

Verification
REQ-033 Bench SHALL write 0x03F800000, 0x040400000, 0x040A00000, 0x040E00000, 0x041100000, 0x100000000 with if_read=1 -> reads 1.0, 3.0, 5.0, 7.0, 9.0, then EoT; last_len=5; one eot_pulse.
REQ-034 Bench SHALL write 5 tokens with if_read=0, DEPTH=4 -> if_full_n=0 after the 4th, 5th write ignored, occupancy=4.
REQ-035 Bench SHALL, when full, assert if_read and if_write together -> only the read is accepted, occupancy=3, then if_full_n=1.
REQ-036 Bench SHALL, when empty, assert if_write and if_read together -> if_empty_n=1 next cycle, occupancy=1, no read counted.
REQ-037 Bench SHALL write two consecutive EoT tokens -> two consecutive eot_pulses, last_len=0 after the second.
REQ-038 Bench SHALL pull ap_rst_n low with 3 stored tokens and elem_count=2 -> all of REQ-028 holds the same cycle; if_full_n=1 after release.
